conv_result_pool: RTL and testbench
===================================

// Module: conv_result_pool
// PURPOSE
//   Downstream stage of the Conv2d array. Captures one flat Conv2d result vector
//   (FILTERBATCH maps of RESHEIGHT x RESWIDTH, 2*BITWIDTH signed each) on a valid/ready handshake.
//   Applies ReLU, POOLSIZE x POOLSIZE max-pooling and requantisation to BITWIDTH unsigned.
//   Streams one pooled pixel per beat to the next layer.
// PARAMETERS
//   BITWIDTH    8  output width; input elements are 2*BITWIDTH signed
//   FILTERBATCH 1  number of feature maps (channels) in the result vector
//   RESHEIGHT   4  rows per feature map
//   RESWIDTH    4  columns per feature map
//   POOLSIZE    2  pooling window edge and stride (non-overlapping)
//   SHIFT       4  requantisation right shift, 0..2*BITWIDTH-1
// PORTS
//   clk       in   1   clock, all state on rising edge
//   rst       in   1   asynchronous, active-high reset
//   in_valid  in   1   in_data holds a complete result vector
//   in_ready  out  1   block can accept a vector (high only in IDLE)
//   in_data   in   2*BITWIDTH*FILTERBATCH*RESHEIGHT*RESWIDTH  Conv2d result vector
//   out_valid out  1   out_data/out_last valid
//   out_ready in   1   consumer accepts the beat
//   out_data  out  BITWIDTH  pooled, requantised pixel (unsigned)
//   out_last  out  1   high on final beat of the frame
// BEHAVIOUR
// - Element e = c*RESHEIGHT*RESWIDTH + r*RESWIDTH + x lives at in_data[e*2*BITWIDTH +: 2*BITWIDTH], signed.
// - Output grid: PH=RESHEIGHT/POOLSIZE, PW=RESWIDTH/POOLSIZE (floor); trailing rows/cols dropped.
// - Beat order: channel-major, then row-major (py, then px).
// - Frame = FILTERBATCH*PH*PW beats.
// - Reset (async): state=IDLE, all counters 0, out_valid=0, out_data=0, out_last=0, in_ready=1.
// - FSM IDLE:
//   - in_ready=1.
//   - on in_valid&in_ready: register in_data in full; clear ch/py/px/wy/wx; set max to most-negative; go SCAN.
// - FSM SCAN:
//   - in_ready=0. Each cycle reads element (ch, py*P+wy, px*P+wx) and updates the running signed max; wx is inner.
//   - On the P*P-th element, load out_data with the requantised max; set out_valid=1.
//   - out_last=1 iff ch,py,px are last. Go EMIT.
// - FSM EMIT:
//   - out_valid, out_data, out_last held stable until out_ready.
//   - On out_valid&out_ready: out_valid=0; if out_last go IDLE, else advance px->py->ch, reset max, go SCAN.
// - Latency: out_valid rises P*P cycles after the accept edge. Steady throughput is 1 beat per P*P+1 cycles with out_ready=1.
// - Requantise: m = max<0 ? 0 : max (ReLU); q = m >>> SHIFT.
//   - out_data = q > 2^BITWIDTH-1 ? 2^BITWIDTH-1 : q[BITWIDTH-1:0].
// - in_data may change after accept; the captured copy is used.
// - in_valid outside IDLE is ignored, not queued.
// - PH or PW = 0: accept, then return to IDLE with no beats.
// - rst mid-SCAN/EMIT: frame discarded, no partial beat emitted; next frame processes cleanly.
// TESTING
// 1. FB=1, 2x2, P=2, SHIFT=0; elems {5,-3,200,7} -> one beat 200, out_last=1,
//    out_valid 4 cycles after accept.
// 2. Same cfg, max elem 0x1234, SHIFT=4 -> 0x123 saturates -> out_data=0xFF.
// 3. All elements negative (-1,-128,-32768,-5) -> out_data=0x00 (ReLU).
// 4. out_ready low 5 cycles in EMIT -> out_data/out_last stable, in_ready=0 throughout,
//    beat completes on out_ready.
// 5. FB=2, 4x4, P=2, SHIFT=0, elem=e -> beats 5,7,13,15,21,23,29,31; out_last on 8th only.
// 6. rst pulse mid-SCAN -> out_valid=0, in_ready=1 after release; next frame (test 1 data) -> 200.

Source files
------------

// File: rtl/conv_result_pool.sv
// Post-Conv2d stage: captures a result vector and applies ReLU and non-overlapping max-pooling.
// Each pooled pixel is requantised to BITWIDTH unsigned bits and streamed one beat at a time.
module conv_result_pool #(
  parameter int BITWIDTH    = 8,
  parameter int FILTERBATCH = 1,
  parameter int RESHEIGHT   = 4,
  parameter int RESWIDTH    = 4,
  parameter int POOLSIZE    = 2,
  parameter int SHIFT       = 4
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [2*BITWIDTH*FILTERBATCH*RESHEIGHT*RESWIDTH-1:0] in_data,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [BITWIDTH-1:0]                               out_data,
  output logic                                              out_last
);

  localparam int ELW   = 2 * BITWIDTH;
  localparam int VW    = ELW * FILTERBATCH * RESHEIGHT * RESWIDTH;
  localparam int PH    = RESHEIGHT / POOLSIZE;
  localparam int PW    = RESWIDTH / POOLSIZE;
  localparam bit EMPTY = (PH == 0) || (PW == 0);
  localparam int CW    = (FILTERBATCH > 1) ? $clog2(FILTERBATCH) : 1;
  localparam int YW    = (PH > 1) ? $clog2(PH) : 1;
  localparam int XW    = (PW > 1) ? $clog2(PW) : 1;
  localparam int WW    = (POOLSIZE > 1) ? $clog2(POOLSIZE) : 1;

  localparam logic [CW-1:0] CH_LAST = CW'(FILTERBATCH - 1);
  localparam logic [YW-1:0] PY_LAST = YW'(PH - 1);
  localparam logic [XW-1:0] PX_LAST = XW'(PW - 1);
  localparam logic [WW-1:0] W_LAST  = WW'(POOLSIZE - 1);
  localparam logic signed [ELW-1:0] MOST_NEG = {1'b1, {(ELW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } state_t;

  // ReLU, arithmetic shift of a non-negative value, then saturate to the output width.
  function automatic logic [BITWIDTH-1:0] requant(input logic signed [ELW-1:0] m);
    logic [ELW-1:0] relu;
    logic [ELW-1:0] q;
    relu = m[ELW-1] ? {ELW{1'b0}} : m;
    q    = relu >> SHIFT;
    if (|q[ELW-1:BITWIDTH]) begin
      requant = {BITWIDTH{1'b1}};
    end else begin
      requant = q[BITWIDTH-1:0];
    end
  endfunction

  state_t                 state_q, state_d;
  logic [VW-1:0]          data_q, data_d;
  logic [CW-1:0]          ch_q, ch_d;
  logic [YW-1:0]          py_q, py_d;
  logic [XW-1:0]          px_q, px_d;
  logic [WW-1:0]          wy_q, wy_d;
  logic [WW-1:0]          wx_q, wx_d;
  logic signed [ELW-1:0]  max_q, max_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [BITWIDTH-1:0]    out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;

  logic [31:0]            idx_s;
  logic signed [ELW-1:0]  elem_s;
  logic signed [ELW-1:0]  max_upd_s;

  // Element currently under the pooling window and the running max including it.
  always_comb begin
    idx_s = 32'(ch_q) * 32'(RESHEIGHT * RESWIDTH)
          + (32'(py_q) * 32'(POOLSIZE) + 32'(wy_q)) * 32'(RESWIDTH)
          + 32'(px_q) * 32'(POOLSIZE) + 32'(wx_q);
    elem_s = data_q[idx_s*ELW +: ELW];
    if (elem_s > max_q) begin
      max_upd_s = elem_s;
    end else begin
      max_upd_s = max_q;
    end
  end

  // Next-state and output logic of the capture / scan / emit controller.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    ch_d        = ch_q;
    py_d        = py_q;
    px_d        = px_q;
    wy_d        = wy_q;
    wx_d        = wx_q;
    max_d       = max_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          data_d = in_data;
          ch_d   = {CW{1'b0}};
          py_d   = {YW{1'b0}};
          px_d   = {XW{1'b0}};
          wy_d   = {WW{1'b0}};
          wx_d   = {WW{1'b0}};
          max_d  = MOST_NEG;
          // A grid with no pooled pixels is accepted and dropped on the spot.
          if (EMPTY) begin
            state_d    = IDLE;
            in_ready_d = 1'b1;
          end else begin
            state_d    = SCAN;
            in_ready_d = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        max_d = max_upd_s;
        if (wx_q == W_LAST) begin
          wx_d = {WW{1'b0}};
          if (wy_q == W_LAST) begin
            wy_d        = {WW{1'b0}};
            out_data_d  = requant(max_upd_s);
            out_valid_d = 1'b1;
            out_last_d  = (ch_q == CH_LAST) && (py_q == PY_LAST) && (px_q == PX_LAST);
            state_d     = EMIT;
          end else begin
            wy_d = wy_q + WW'(1);
          end
        end else begin
          wx_d = wx_q + WW'(1);
        end
      end
      EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d    = IDLE;
            in_ready_d = 1'b1;
          end else begin
            max_d   = MOST_NEG;
            state_d = SCAN;
            if (px_q == PX_LAST) begin
              px_d = {XW{1'b0}};
              if (py_q == PY_LAST) begin
                py_d = {YW{1'b0}};
                ch_d = ch_q + CW'(1);
              end else begin
                py_d = py_q + YW'(1);
              end
            end else begin
              px_d = px_q + XW'(1);
            end
          end
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= {VW{1'b0}};
      ch_q        <= {CW{1'b0}};
      py_q        <= {YW{1'b0}};
      px_q        <= {XW{1'b0}};
      wy_q        <= {WW{1'b0}};
      wx_q        <= {WW{1'b0}};
      max_q       <= MOST_NEG;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= {BITWIDTH{1'b0}};
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      ch_q        <= ch_d;
      py_q        <= py_d;
      px_q        <= px_d;
      wy_q        <= wy_d;
      wx_q        <= wx_d;
      max_q       <= max_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv_result_pool.sv
// Self-checking bench for conv_result_pool: a vector table on a 2x2 instance, hand-written
// stall and reset sequences, a fixed 4x4 two-channel case, an empty-grid case and random frames.
module tb_conv_result_pool;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // A: FB=1 2x2 P=2 SHIFT=0
  logic a_iv = 1'b0, a_ir, a_ov, a_or = 1'b0, a_ol;
  logic [63:0] a_data = 64'd0;
  logic [7:0]  a_od;
  conv_result_pool #(.BITWIDTH(8), .FILTERBATCH(1), .RESHEIGHT(2), .RESWIDTH(2), .POOLSIZE(2), .SHIFT(0))
    u_a (.clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_data),
         .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_last(a_ol));

  // B: FB=2 4x4 P=2 SHIFT=0
  logic b_iv = 1'b0, b_ir, b_ov, b_or = 1'b0, b_ol;
  logic [511:0] b_data = 512'd0;
  logic [7:0]   b_od;
  conv_result_pool #(.BITWIDTH(8), .FILTERBATCH(2), .RESHEIGHT(4), .RESWIDTH(4), .POOLSIZE(2), .SHIFT(0))
    u_b (.clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_data),
         .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .out_last(b_ol));

  // R: FB=2 5x7 P=2 SHIFT=3 (trailing row/col dropped), random traffic
  logic r_iv = 1'b0, r_ir, r_ov, r_or = 1'b0, r_ol;
  logic [1119:0] r_data = 1120'd0;
  logic [7:0]    r_od;
  conv_result_pool #(.BITWIDTH(8), .FILTERBATCH(2), .RESHEIGHT(5), .RESWIDTH(7), .POOLSIZE(2), .SHIFT(3))
    u_r (.clk(clk), .rst(rst), .in_valid(r_iv), .in_ready(r_ir), .in_data(r_data),
         .out_valid(r_ov), .out_ready(r_or), .out_data(r_od), .out_last(r_ol));

  // E: 1x4 with P=2 gives an empty output grid
  logic e_iv = 1'b0, e_ir, e_ov, e_or = 1'b1, e_ol;
  logic [63:0] e_data = 64'd0;
  logic [7:0]  e_od;
  conv_result_pool #(.BITWIDTH(8), .FILTERBATCH(1), .RESHEIGHT(1), .RESWIDTH(4), .POOLSIZE(2), .SHIFT(0))
    u_e (.clk(clk), .rst(rst), .in_valid(e_iv), .in_ready(e_ir), .in_data(e_data),
         .out_valid(e_ov), .out_ready(e_or), .out_data(e_od), .out_last(e_ol));

  typedef struct {
    string       name;
    logic [63:0] data;
    logic [7:0]  exp;
  } a_vec_t;

  // Reference: pooled, requantised pixels in channel/row/column order, pushed onto exp_q.
  task automatic model(input int v[], input int fb, input int rh, input int rw, input int p, input int sh);
    for (int c = 0; c < fb; c++)
      for (int py = 0; py < rh / p; py++)
        for (int px = 0; px < rw / p; px++) begin
          int m;
          m = -2147483647;
          for (int wy = 0; wy < p; wy++)
            for (int wx = 0; wx < p; wx++)
              if (v[c*rh*rw + (py*p+wy)*rw + px*p + wx] > m) m = v[c*rh*rw + (py*p+wy)*rw + px*p + wx];
          if (m < 0) m = 0;
          m = m >>> sh;
          if (m > 255) m = 255;
          exp_q.push_back(m);
        end
  endtask

  task automatic a_frame(input string nm, input logic [63:0] d, input logic [7:0] exp, input int stall);
    int k;
    @(negedge clk);
    check({nm, "_ready_idle"}, 32'(a_ir), 32'd1);
    a_data = d;
    a_iv   = 1'b1;
    @(negedge clk);
    a_iv   = 1'b0;
    a_data = {$urandom, $urandom};
    k = 0;
    while (!a_ov && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_latency"}, 32'(k), 32'd4);
    check({nm, "_data"}, 32'(a_od), 32'(exp));
    check({nm, "_last"}, 32'(a_ol), 32'd1);
    check({nm, "_ready_busy"}, 32'(a_ir), 32'd0);
    for (int s = 0; s < stall; s++) begin
      a_iv   = 1'b1;
      a_data = {$urandom, $urandom};
      @(negedge clk);
      check({nm, "_stall_valid"}, 32'(a_ov), 32'd1);
      check({nm, "_stall_data"}, 32'(a_od), 32'(exp));
      check({nm, "_stall_last"}, 32'(a_ol), 32'd1);
      check({nm, "_stall_ready"}, 32'(a_ir), 32'd0);
    end
    a_iv = 1'b0;
    a_or = 1'b1;
    @(negedge clk);
    a_or = 1'b0;
    check({nm, "_valid_drop"}, 32'(a_ov), 32'd0);
    check({nm, "_ready_back"}, 32'(a_ir), 32'd1);
    if (stall > 0) begin
      for (int s = 0; s < 6; s++) begin
        @(negedge clk);
        check({nm, "_no_queued_frame"}, 32'(a_ov), 32'd0);
      end
    end
  endtask

  task automatic r_frame(input int f);
    int v[];
    int cyc;
    int left;
    logic signed [15:0] t;
    v = new[70];
    for (int e = 0; e < 70; e++) begin
      case ($urandom_range(0, 3))
        0: t = 16'($urandom);
        1: t = 16'($urandom_range(0, 300));
        2: t = -16'($urandom_range(1, 50));
        default: t = 16'($urandom_range(0, 4095));
      endcase
      v[e] = int'(t);
      r_data[e*16 +: 16] = t;
    end
    exp_q = {};
    model(v, 2, 5, 7, 2, 3);
    @(negedge clk);
    r_iv = 1'b1;
    @(negedge clk);
    r_iv = 1'b0;
    r_data = {35{$urandom}};
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 2000) begin
      r_or = ($urandom_range(0, 3) != 0);
      if (r_ov && r_or) begin
        left = exp_q.size();
        check($sformatf("rand_f%0d_data", f), 32'(r_od), 32'(exp_q[0]));
        check($sformatf("rand_f%0d_last", f), 32'(r_ol), 32'(left == 1));
        void'(exp_q.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    r_or = 1'b0;
    check($sformatf("rand_f%0d_beats_left", f), 32'(exp_q.size()), 32'd0);
    check($sformatf("rand_f%0d_ready_back", f), 32'(r_ir), 32'd1);
  endtask

  initial begin
    a_vec_t vecs[8];
    int k;
    int b_exp[8];
    logic [63:0] t1;

    t1 = {16'h0007, 16'h00C8, 16'hFFFD, 16'h0005};
    vecs[0] = '{"relu_max", t1, 8'hC8};
    vecs[1] = '{"sat_1234", {16'h0003, 16'h0002, 16'h0001, 16'h1234}, 8'hFF};
    vecs[2] = '{"all_neg",  {16'hFFFB, 16'h8000, 16'hFF80, 16'hFFFF}, 8'h00};
    vecs[3] = '{"zeros",    64'd0, 8'h00};
    vecs[4] = '{"exact255", {16'h00FE, 16'h8000, 16'h0001, 16'h00FF}, 8'hFF};
    vecs[5] = '{"sat256",   {16'h0000, 16'h0000, 16'h0000, 16'h0100}, 8'hFF};
    vecs[6] = '{"max_last", {16'h002A, 16'h0000, 16'h0000, 16'h0000}, 8'h2A};
    vecs[7] = '{"mixed",    {16'h003F, 16'h0041, 16'h8001, 16'h0040}, 8'h41};
    b_exp = '{5, 7, 13, 15, 21, 23, 29, 31};

    @(negedge clk);
    check("rst_out_valid", 32'(a_ov), 32'd0);
    check("rst_out_data", 32'(a_od), 32'd0);
    check("rst_out_last", 32'(a_ol), 32'd0);
    check("rst_in_ready", 32'(a_ir), 32'd1);
    check("rst_b_in_ready", 32'(b_ir), 32'd1);
    check("rst_b_out_valid", 32'(b_ov), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) a_frame(vecs[i].name, vecs[i].data, vecs[i].exp, 0);

    a_frame("stall5", t1, 8'hC8, 5);

    // Reset in the middle of a scan: frame is dropped, next one runs cleanly.
    @(negedge clk);
    a_data = {16'h0000, 16'h0000, 16'h0000, 16'h0063};
    a_iv   = 1'b1;
    @(negedge clk);
    a_iv = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_async_valid", 32'(a_ov), 32'd0);
    check("midrst_async_ready", 32'(a_ir), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      check("midrst_no_beat", 32'(a_ov), 32'd0);
    end
    a_frame("after_rst", t1, 8'hC8, 0);

    // Two channels of 4x4 with element value equal to its index.
    for (int e = 0; e < 32; e++) b_data[e*16 +: 16] = 16'(e);
    @(negedge clk);
    b_iv = 1'b1;
    @(negedge clk);
    b_iv   = 1'b0;
    b_data = {16{$urandom}};
    b_or   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      k = 0;
      while (!b_ov && k < 20) begin
        @(negedge clk);
        k++;
      end
      check($sformatf("fb2_beat%0d_gap", i), 32'(k), 32'd4);
      check($sformatf("fb2_beat%0d_data", i), 32'(b_od), 32'(b_exp[i]));
      check($sformatf("fb2_beat%0d_last", i), 32'(b_ol), 32'(i == 7));
      @(negedge clk);
    end
    b_or = 1'b0;
    check("fb2_ready_back", 32'(b_ir), 32'd1);
    check("fb2_valid_drop", 32'(b_ov), 32'd0);

    // Empty output grid: accepted, no beats produced.
    @(negedge clk);
    e_data = {$urandom, $urandom};
    e_iv   = 1'b1;
    check("empty_ready", 32'(e_ir), 32'd1);
    @(negedge clk);
    e_iv = 1'b0;
    for (int s = 0; s < 6; s++) begin
      check("empty_no_valid", 32'(e_ov), 32'd0);
      check("empty_ready_held", 32'(e_ir), 32'd1);
      @(negedge clk);
    end
    check("empty_no_last", 32'(e_ol), 32'd0);
    check("empty_data_zero", 32'(e_od), 32'd0);

    for (int f = 0; f < 6; f++) r_frame(f);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
